// File: rtl/hazard_sequencer.sv
// Load-use and branch/jump hazard sequencer for the 16-bit pipelined MIPS core.
// Optional stall counter built only when HAZ_SEQ_PERF_EN is defined.
module hazard_sequencer #(
  parameter logic [2:0]  OP_LW     = 3'b010,
  parameter logic [2:0]  OP_BEQ    = 3'b100,
  parameter logic [2:0]  OP_JMP    = 3'b101,
  parameter int unsigned BR_DELAY  = 2,
  parameter int unsigned JMP_DELAY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] if_id_instr,
  input  logic        if_id_valid,
  input  logic [2:0]  id_ex_opcode,
  input  logic [2:0]  id_ex_rt,
  input  logic        ex_redirect,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [1:0]  seq_state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CTRL_WAIT = 2'd1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;

  logic [2:0] opcode, rs, rt;
  logic       load_use;
  logic       unused_bits;

  assign opcode      = if_id_instr[15:13];
  assign rs          = if_id_instr[12:10];
  assign rt          = if_id_instr[9:7];
  assign unused_bits = ^if_id_instr[6:0];

  // LW and JMP never read rt, so only rs can create a dependency for them
  assign load_use = if_id_valid && (id_ex_opcode == OP_LW) && (id_ex_rt != 3'd0) &&
                    ((id_ex_rt == rs) ||
                     ((id_ex_rt == rt) && (opcode != OP_LW) && (opcode != OP_JMP)));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_use) begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (if_id_valid && (opcode == OP_BEQ)) begin
          state_d    = CTRL_WAIT;
          wait_cnt_d = 2'(BR_DELAY);
        end else if (if_id_valid && (opcode == OP_JMP)) begin
          state_d    = CTRL_WAIT;
          wait_cnt_d = 2'(JMP_DELAY);
        end
      end
      CTRL_WAIT: begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        wait_cnt_d  = wait_cnt_q - 2'd1;
        // An early EX redirect ends the wait; clear the count so IDLE is clean
        if ((wait_cnt_q == 2'd1) || ex_redirect) begin
          state_d    = IDLE;
          wait_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign seq_state = state_q;

`ifdef HAZ_SEQ_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed literal checks plus
// randomized traffic compared every cycle against a flush-countdown model.
module tb_hazard_sequencer;

  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam int BR_DELAY  = 2;
  localparam int JMP_DELAY = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] if_id_instr;
  logic        if_id_valid;
  logic [2:0]  id_ex_opcode;
  logic [2:0]  id_ex_rt;
  logic        ex_redirect;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_bubble;
  logic [1:0]  seq_state;
  logic [15:0] stall_cycles;

  int tests_run = 0;
  int fails     = 0;
  logic check_en = 1'b0;

  hazard_sequencer #(
    .OP_LW(OP_LW), .OP_BEQ(OP_BEQ), .OP_JMP(OP_JMP),
    .BR_DELAY(BR_DELAY), .JMP_DELAY(JMP_DELAY)
  ) dut (
    .clock(clock), .reset(reset), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .id_ex_opcode(id_ex_opcode), .id_ex_rt(id_ex_rt), .ex_redirect(ex_redirect),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .seq_state(seq_state), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Model: number of flush cycles still owed, and total cycles spent holding the PC
  int m_left = 0;
  int m_cnt  = 0;
  logic       exp_load_use;
  logic [5:0] exp_vec;
  logic [15:0] exp_stall;
  logic [5:0] dut_vec;

  assign dut_vec = {seq_state, pc_hold, if_id_hold, if_id_flush, id_ex_bubble};

  always_comb begin
    logic [2:0] op, rs, rt;
    op = if_id_instr[15:13];
    rs = if_id_instr[12:10];
    rt = if_id_instr[9:7];
    exp_load_use = if_id_valid && id_ex_opcode == OP_LW && id_ex_rt != 0 &&
                   (id_ex_rt == rs || (id_ex_rt == rt && op != OP_LW && op != OP_JMP));
    if (m_left > 0)        exp_vec = 6'b01_1010;
    else if (exp_load_use) exp_vec = 6'b00_1101;
    else                   exp_vec = 6'b00_0000;
`ifdef HAZ_SEQ_PERF_EN
    exp_stall = 16'(m_cnt);
`else
    exp_stall = 16'h0000;
`endif
  end

  always @(posedge clock) begin
    if (reset) begin
      m_left <= 0;
      m_cnt  <= 0;
    end else begin
      if (m_left > 0)
        m_left <= (ex_redirect || m_left == 1) ? 0 : m_left - 1;
      else if (!exp_load_use && if_id_valid && if_id_instr[15:13] == OP_BEQ)
        m_left <= BR_DELAY;
      else if (!exp_load_use && if_id_valid && if_id_instr[15:13] == OP_JMP)
        m_left <= JMP_DELAY;
      if (exp_vec[3] && m_cnt < 65535)
        m_cnt <= m_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model_ctrl", 32'(dut_vec), 32'(exp_vec));
      checkOutput("model_stall", 32'(stall_cycles), 32'(exp_stall));
    end
  end

  // Drive one cycle's inputs just after the rising edge, return after the falling edge
  task automatic applyStimulus(input logic rst, input logic valid, input logic [15:0] instr,
                               input logic [2:0] idop, input logic [2:0] idrt, input logic redir);
    @(posedge clock);
    #2;
    reset        = rst;
    if_id_valid  = valid;
    if_id_instr  = instr;
    id_ex_opcode = idop;
    id_ex_rt     = idrt;
    ex_redirect  = redir;
    @(negedge clock);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt);
    return {op, rs, rt, 7'd0};
  endfunction

  initial begin
    reset = 1'b1; if_id_valid = 1'b0; if_id_instr = '0;
    id_ex_opcode = OP_NOP; id_ex_rt = '0; ex_redirect = 1'b0;

    applyStimulus(1, 0, 16'h0, OP_NOP, 0, 0);
    check_en = 1'b1;
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("reset_ctrl", 32'(dut_vec), 32'h0);
    checkOutput("reset_stall", 32'(stall_cycles), 32'h0);

    applyStimulus(0, 1, mk(3'b000, 3, 1), OP_LW, 3, 0);
    checkOutput("loaduse_stall", 32'(dut_vec), 32'b00_1101);
    applyStimulus(0, 1, mk(3'b000, 3, 1), OP_NOP, 0, 0);
    checkOutput("loaduse_clear", 32'(dut_vec), 32'h0);
    applyStimulus(0, 1, mk(3'b000, 0, 1), OP_LW, 0, 0);
    checkOutput("loaduse_r0", 32'(dut_vec), 32'h0);

    applyStimulus(0, 1, mk(OP_BEQ, 1, 2), OP_NOP, 0, 0);
    checkOutput("beq_detect", 32'(dut_vec), 32'h0);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("beq_flush1", 32'(dut_vec), 32'b01_1010);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("beq_flush2", 32'(dut_vec), 32'b01_1010);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("beq_idle", 32'(dut_vec), 32'h0);

    applyStimulus(0, 1, mk(OP_JMP, 0, 0), OP_NOP, 0, 0);
    checkOutput("jmp_detect", 32'(dut_vec), 32'h0);
    applyStimulus(0, 1, mk(3'b000, 1, 1), OP_NOP, 0, 1);
    checkOutput("jmp_redirect_flush", 32'(dut_vec), 32'b01_1010);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("jmp_idle", 32'(dut_vec), 32'h0);

    applyStimulus(1, 0, 16'h0, OP_NOP, 0, 0);
    applyStimulus(0, 1, mk(OP_BEQ, 5, 2), OP_LW, 5, 0);
    checkOutput("beqlw_stall", 32'(dut_vec), 32'b00_1101);
    applyStimulus(0, 1, mk(OP_BEQ, 5, 2), OP_NOP, 0, 0);
    checkOutput("beqlw_detect", 32'(dut_vec), 32'h0);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("beqlw_flush1", 32'(dut_vec), 32'b01_1010);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("beqlw_flush2", 32'(dut_vec), 32'b01_1010);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("beqlw_idle", 32'(dut_vec), 32'h0);
`ifdef HAZ_SEQ_PERF_EN
    checkOutput("beqlw_count", 32'(stall_cycles), 32'd3);
`else
    checkOutput("beqlw_count", 32'(stall_cycles), 32'd0);
`endif

    applyStimulus(0, 1, mk(OP_BEQ, 1, 1), OP_NOP, 0, 0);
    applyStimulus(1, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("rst_in_wait_flush", 32'(dut_vec), 32'b01_1010);
    applyStimulus(0, 0, 16'h0, OP_NOP, 0, 0);
    checkOutput("rst_in_wait_idle", 32'(dut_vec), 32'h0);
    checkOutput("rst_in_wait_count", 32'(stall_cycles), 32'h0);

`ifdef HAZ_SEQ_PERF_EN
    for (int i = 0; i < 65538; i++)
      applyStimulus(0, 1, mk(3'b000, 3, 1), OP_LW, 3, 0);
    checkOutput("sat_reach", 32'(stall_cycles), 32'hFFFF);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, mk(3'b000, 3, 1), OP_LW, 3, 0);
    checkOutput("sat_hold", 32'(stall_cycles), 32'hFFFF);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] idop;
      idop = ($urandom_range(1) == 1) ? OP_LW : 3'($urandom);
      applyStimulus($urandom_range(49) == 0, $urandom_range(3) != 0, 16'($urandom),
                    idop, 3'($urandom), $urandom_range(3) == 0);
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard sequencer for the 16-bit pipelined MIPS core. It sits between the IF/ID and ID/EX pipeline registers and the PC logic. It detects load-use data hazards and branch/jump control hazards on the instruction in IF/ID. It then drives PC-hold, IF/ID-flush and ID/EX-bubble controls, using a small state machine and a delay counter.

## Interface
Parameters:
- OP_LW, 3'b010, opcode of load word
- OP_BEQ, 3'b100, opcode of conditional branch
- OP_JMP, 3'b101, opcode of jump
- BR_DELAY, 2, wait cycles after a branch leaves ID (legal 1..3)
- JMP_DELAY, 1, wait cycles after a jump leaves ID (legal 1..3)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_id_instr  in  16  instruction in IF/ID; opcode [15:13], rs [12:10], rt [9:7]
- if_id_valid  in  1  IF/ID holds a real instruction
- id_ex_opcode  in  3  opcode of the instruction in ID/EX
- id_ex_rt  in  3  destination register of the instruction in ID/EX
- ex_redirect  in  1  EX has resolved a branch/jump and is redirecting the PC this cycle
- pc_hold  out  1  freeze PC; the external EX redirect overrides it
- if_id_hold  out  1  freeze IF/ID
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- seq_state  out  2  current state: 0 IDLE, 1 CTRL_WAIT
- stall_cycles  out  16  saturating count of cycles with pc_hold=1

## Operation
- States are IDLE and CTRL_WAIT. A 2-bit down-counter `wait_cnt` runs in CTRL_WAIT.
- Load-use hazard (IDLE only, combinational) fires when all of the following hold:
  - if_id_valid=1
  - id_ex_opcode==OP_LW
  - id_ex_rt!=0
  - id_ex_rt equals rs, or id_ex_rt equals rt when the IF/ID opcode is neither OP_LW nor OP_JMP
- On a load-use hazard: pc_hold=1, if_id_hold=1, id_ex_bubble=1 for that cycle. State stays IDLE. The next cycle ID/EX holds a bubble, so the hazard clears by itself.
- Control hazard (IDLE only): if_id_valid=1 and the IF/ID opcode is OP_BEQ or OP_JMP, with no load-use hazard.
  - Outputs stay 0 in the detection cycle, so the branch advances to ID/EX.
  - Next state is CTRL_WAIT with wait_cnt = BR_DELAY or JMP_DELAY.
- Load-use has priority over a control hazard. A branch that needs a loaded operand is held one cycle first, then detected as a control hazard.
- CTRL_WAIT:
  - Outputs: pc_hold=1, if_id_flush=1, if_id_hold=0, id_ex_bubble=0.
  - wait_cnt decrements each cycle. When wait_cnt==1, or when ex_redirect=1, next state is IDLE.
  - The IF/ID contents are ignored.
- ex_redirect has no effect in IDLE.
- if_id_valid=0 in IDLE leaves all outputs 0 and no state change.
- Every output is a function of the current state and current inputs only. There is no combinational path from ex_redirect to the outputs.

## Timing
- Reset values: state IDLE, wait_cnt 0, stall_cycles 0. pc_hold, if_id_hold, if_id_flush and id_ex_bubble are all 0.
- Reset asserted mid-CTRL_WAIT: IDLE on the next edge, with no residual flush.
- Load-use adds exactly 1 stall cycle.
- Branch adds BR_DELAY flush cycles; jump adds JMP_DELAY flush cycles.
- With ex_redirect=1 in the first CTRL_WAIT cycle, the wait is exactly 1 cycle.
- A back-to-back branch is detected in the first IDLE cycle after CTRL_WAIT.
- stall_cycles increments at the edge ending any cycle with pc_hold=1 and holds at 16'hFFFF.

## Configuration
- HAZ_SEQ_PERF_EN defined: the stall_cycles counter is built as described above.
- HAZ_SEQ_PERF_EN undefined: there is no counter logic, and stall_cycles is tied to 16'h0000.
- All other behaviour is identical in both builds.

## Test plan
- Reset during CTRL_WAIT (wait_cnt=2) → the next cycle has seq_state=0 and all outputs 0. stall_cycles reads 0 with the macro defined.
- id_ex_opcode=OP_LW, id_ex_rt=3, IF/ID add with rs=3 → pc_hold, if_id_hold and id_ex_bubble are 1 for one cycle, then 0 once id_ex_opcode becomes the NOP opcode. With id_ex_rt=0 there is no stall.
- IF/ID BEQ with BR_DELAY=2 and ex_redirect=0 → detection cycle outputs 0, then if_id_flush=pc_hold=1 for 2 cycles, then IDLE.
- IF/ID JMP, with ex_redirect=1 in the first CTRL_WAIT cycle → exactly 1 flush cycle, and IDLE on the next edge.
- BEQ with rs=5 while ID/EX holds LW with rt=5 → 1 load-use stall cycle, then branch detection, then 2 flush cycles, for 3 total pc_hold cycles. stall_cycles reads 3.
- Macro defined, counter preloaded to 16'hFFFE, 3 stall cycles → stall_cycles reads 16'hFFFF and stays there.
